// File: rtl/ghash_feeder.sv
`timescale 1ns/1ps
// GHASH input formatter: AAD blocks, then CT blocks, then len(A)||len(C),
// with zero padding of partial tail blocks and a last flag on the length block.
module ghash_feeder #(
  parameter int unsigned CNT_W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         has_aad_i,
  input  logic         has_ct_i,
  output logic         busy_o,
  input  logic [127:0] aad_i,
  input  logic         aad_valid_i,
  input  logic         aad_last_i,
  input  logic [4:0]   aad_bytes_i,
  output logic         aad_ready_o,
  input  logic [127:0] ct_i,
  input  logic         ct_valid_i,
  input  logic         ct_last_i,
  input  logic [4:0]   ct_bytes_i,
  output logic         ct_ready_o,
  output logic [127:0] blk_o,
  output logic         blk_valid_o,
  output logic         blk_last_o,
  input  logic         blk_ready_i
);

  localparam int unsigned BLK_W = 128;
  localparam int unsigned LEN_W = 64;

  typedef enum logic [1:0] {IDLE, AAD, CT, LEN} state_t;

  state_t           state;
  logic [CNT_W-1:0] aad_cnt;
  logic [CNT_W-1:0] ct_cnt;
  logic             has_ct_q;

  logic             slot_free_c;
  logic             aad_acc_c;
  logic             ct_acc_c;
  logic [BLK_W-1:0] aad_blk_c;
  logic [BLK_W-1:0] ct_blk_c;

  // A byte count of 0 or above 16 means a full block.
  function automatic logic [4:0] eff_bytes(input logic [4:0] nbytes);
    return ((nbytes == 5'd0) || (nbytes > 5'd16)) ? 5'd16 : nbytes;
  endfunction

  // Keep bytes 0..n-1 (byte 0 is the MSB byte), zero the rest.
  function automatic logic [BLK_W-1:0] pad_blk(input logic [BLK_W-1:0] d,
                                               input logic [4:0] nbytes);
    logic [4:0] rem;
    logic [6:0] sh;
    rem = 5'd16 - nbytes;
    sh  = 7'({rem[3:0], 3'b000});
    return d & ({BLK_W{1'b1}} << sh);
  endfunction

  function automatic logic [CNT_W-1:0] blk_bits(input logic last,
                                               input logic [4:0] nbytes);
    logic [7:0] bits;
    bits = last ? {eff_bytes(nbytes), 3'b000} : 8'd128;
    return CNT_W'(bits);
  endfunction

  // Output register can take a new block when empty or being drained this cycle.
  assign slot_free_c = !blk_valid_o || blk_ready_i;
  assign aad_ready_o = (state == AAD) && slot_free_c;
  assign ct_ready_o  = (state == CT) && slot_free_c;
  assign aad_acc_c   = aad_ready_o && aad_valid_i;
  assign ct_acc_c    = ct_ready_o && ct_valid_i;
  assign aad_blk_c   = aad_last_i ? pad_blk(aad_i, eff_bytes(aad_bytes_i)) : aad_i;
  assign ct_blk_c    = ct_last_i ? pad_blk(ct_i, eff_bytes(ct_bytes_i)) : ct_i;

  // Phase sequencer, length counters and the single output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      aad_cnt     <= '0;
      ct_cnt      <= '0;
      has_ct_q    <= 1'b0;
      busy_o      <= 1'b0;
      blk_o       <= '0;
      blk_valid_o <= 1'b0;
      blk_last_o  <= 1'b0;
    end else begin
      if (blk_valid_o && blk_ready_i) begin
        blk_valid_o <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start_i) begin
            aad_cnt  <= '0;
            ct_cnt   <= '0;
            has_ct_q <= has_ct_i;
            busy_o   <= 1'b1;
            if (has_aad_i) begin
              state <= AAD;
            end else if (has_ct_i) begin
              state <= CT;
            end else begin
              state <= LEN;
            end
          end
        end
        AAD: begin
          if (aad_acc_c) begin
            blk_o       <= aad_blk_c;
            blk_valid_o <= 1'b1;
            blk_last_o  <= 1'b0;
            aad_cnt     <= aad_cnt + blk_bits(aad_last_i, aad_bytes_i);
            if (aad_last_i) begin
              state <= has_ct_q ? CT : LEN;
            end
          end
        end
        CT: begin
          if (ct_acc_c) begin
            blk_o       <= ct_blk_c;
            blk_valid_o <= 1'b1;
            blk_last_o  <= 1'b0;
            ct_cnt      <= ct_cnt + blk_bits(ct_last_i, ct_bytes_i);
            if (ct_last_i) begin
              state <= LEN;
            end
          end
        end
        LEN: begin
          if (slot_free_c) begin
            blk_o       <= {LEN_W'(aad_cnt), LEN_W'(ct_cnt)};
            blk_valid_o <= 1'b1;
            blk_last_o  <= 1'b1;
            busy_o      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
